led_display_panel_rx: RTL

- Panel-side receiver for the HUB75-style interface driven by the display driver PHY.
- Samples bit clock, RGB data, latch, output enable and row address, and rebuilds each latched row pair.
- Streams the rebuilt pixels out as (x, y, rgb) over a valid/ready handshake.
- Used as a self-checking panel model in simulation and as an FPGA loopback monitor.

---
 rtl/led_display_panel_rx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/led_display_panel_rx.sv
// HUB75 panel-side receiver: rebuilds each latched row pair and streams it out as (x, y, rgb).
// Optional ghosting check on address changes while OE is active: define LED_RX_OE_CHECK_EN.
module led_display_panel_rx #(
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  localparam int AW = $clog2(NUM_ROW_PIXELS / 2),
  localparam int XW = $clog2(NUM_COL_PIXELS),
  localparam int YW = $clog2(NUM_ROW_PIXELS)
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          hub_bclk_in,
  input  logic [2:0]    hub_rgb_top_in,
  input  logic [2:0]    hub_rgb_bot_in,
  input  logic          hub_latch_in,
  input  logic          hub_oe_n_in,
  input  logic [AW-1:0] hub_addr_in,
  output logic          pix_valid_out,
  input  logic          pix_ready_in,
  output logic [XW-1:0] pix_x_out,
  output logic [YW-1:0] pix_y_out,
  output logic [2:0]    pix_rgb_out,
  output logic          row_done_out,
  output logic          frame_done_out,
  output logic          len_err_out,
  output logic          overrun_out,
  output logic          addr_err_out,
  output logic          busy_out
);

  localparam int CW = $clog2(NUM_COL_PIXELS + 2);
  localparam int IW = XW + 1;
  localparam int SW = 9 + AW;
  localparam logic [CW-1:0] CNT_FULL  = CW'(NUM_COL_PIXELS);
  localparam logic [CW-1:0] CNT_SAT   = CW'(NUM_COL_PIXELS + 1);
  localparam logic [IW-1:0] IDX_HALF  = IW'(NUM_COL_PIXELS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(2 * NUM_COL_PIXELS - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_ROW_PIXELS / 2 - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state_reg, state_next;

  logic [SW-1:0] pins, s1_reg, s2_reg;
  logic          bclk_prev_reg, latch_prev_reg;
  logic [2:0]    s_rgb_top, s_rgb_bot;
  logic          s_bclk, s_latch, s_oe_n;
  logic [AW-1:0] s_addr;
  logic          bclk_rise, latch_rise;

  logic [2:0] top_reg  [NUM_COL_PIXELS];
  logic [2:0] bot_reg  [NUM_COL_PIXELS];
  logic [2:0] top_next [NUM_COL_PIXELS];
  logic [2:0] bot_next [NUM_COL_PIXELS];
  logic [2:0] buf_top  [NUM_COL_PIXELS];
  logic [2:0] buf_bot  [NUM_COL_PIXELS];

  logic [CW-1:0] cnt_reg, cnt_upd;
  logic          len_ok, start, accept, last_accept;
  logic [AW-1:0] addr_reg;
  logic [IW-1:0] idx_reg, sel_idx;
  logic          sel_bot;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic [2:0]    sel_rgb;

  logic          pix_valid_reg, row_done_reg, frame_done_reg, len_err_reg, overrun_reg;
  logic [XW-1:0] pix_x_reg;
  logic [YW-1:0] pix_y_reg;
  logic [2:0]    pix_rgb_reg;

  assign pins = {hub_addr_in, hub_oe_n_in, hub_latch_in, hub_bclk_in, hub_rgb_bot_in, hub_rgb_top_in};
  assign s_rgb_top = s2_reg[2:0];
  assign s_rgb_bot = s2_reg[5:3];
  assign s_bclk    = s2_reg[6];
  assign s_latch   = s2_reg[7];
  assign s_oe_n    = s2_reg[8];
  assign s_addr    = s2_reg[SW-1:9];

  assign bclk_rise  = s_bclk & ~bclk_prev_reg;
  assign latch_rise = s_latch & ~latch_prev_reg;

  // Bit k after a latch ends up at column N-1-k once the full row has been shifted.
  for (genvar gi = 0; gi < NUM_COL_PIXELS; gi++) begin : g_shift
    if (gi == 0) begin : g_head
      assign top_next[gi] = bclk_rise ? s_rgb_top : top_reg[gi];
      assign bot_next[gi] = bclk_rise ? s_rgb_bot : bot_reg[gi];
    end else begin : g_tail
      assign top_next[gi] = bclk_rise ? top_reg[gi-1] : top_reg[gi];
      assign bot_next[gi] = bclk_rise ? bot_reg[gi-1] : bot_reg[gi];
    end
  end

  // A same-cycle shift is counted before the latch looks at the length.
  assign cnt_upd = (bclk_rise && cnt_reg != CNT_SAT) ? cnt_reg + CW'(1) : cnt_reg;
  assign len_ok  = (cnt_upd == CNT_FULL);

  assign accept      = pix_valid_reg & pix_ready_in;
  assign last_accept = accept && (idx_reg == IDX_LAST);
  assign start       = (state_reg == IDLE) && latch_rise && len_ok;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (latch_rise && len_ok) state_next = STREAM;
      STREAM:  if (last_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pixel to be presented after this edge: the next one on accept, else the current one.
  assign sel_idx = pix_valid_reg ? idx_reg + IW'(1) : idx_reg;
  assign sel_bot = (sel_idx >= IDX_HALF);
  assign sel_x   = sel_bot ? XW'(sel_idx - IDX_HALF) : XW'(sel_idx);
  assign sel_y   = sel_bot ? YW'(addr_reg) + YW'(NUM_ROW_PIXELS / 2) : YW'(addr_reg);
  assign sel_rgb = sel_bot ? buf_bot[sel_x] : buf_top[sel_x];

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_reg      <= IDLE;
      s1_reg         <= '0;
      s2_reg         <= '0;
      bclk_prev_reg  <= 1'b0;
      latch_prev_reg <= 1'b0;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      idx_reg        <= '0;
      pix_valid_reg  <= 1'b0;
      pix_x_reg      <= '0;
      pix_y_reg      <= '0;
      pix_rgb_reg    <= '0;
      row_done_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      len_err_reg    <= 1'b0;
      overrun_reg    <= 1'b0;
      for (int i = 0; i < NUM_COL_PIXELS; i++) begin
        top_reg[i] <= '0;
        bot_reg[i] <= '0;
        buf_top[i] <= '0;
        buf_bot[i] <= '0;
      end
    end else begin
      state_reg      <= state_next;
      s1_reg         <= pins;
      s2_reg         <= s1_reg;
      bclk_prev_reg  <= s_bclk;
      latch_prev_reg <= s_latch;
      top_reg        <= top_next;
      bot_reg        <= bot_next;
      cnt_reg        <= latch_rise ? '0 : cnt_upd;
      len_err_reg    <= latch_rise && !len_ok;
      overrun_reg    <= latch_rise && (state_reg == STREAM);
      row_done_reg   <= last_accept;
      frame_done_reg <= last_accept && (addr_reg == ADDR_LAST);

      if (start) begin
        buf_top       <= top_next;
        buf_bot       <= bot_next;
        addr_reg      <= s_addr;
        idx_reg       <= '0;
        pix_valid_reg <= 1'b0;
      end else if (state_reg == STREAM) begin
        if (!pix_valid_reg || (accept && !last_accept)) begin
          pix_valid_reg <= 1'b1;
          idx_reg       <= sel_idx;
          pix_x_reg     <= sel_x;
          pix_y_reg     <= sel_y;
          pix_rgb_reg   <= sel_rgb;
        end else if (last_accept) begin
          pix_valid_reg <= 1'b0;
        end
      end
    end
  end

`ifdef LED_RX_OE_CHECK_EN
  logic [AW-1:0] addr_prev_reg;
  logic          addr_err_reg;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      addr_prev_reg <= '0;
      addr_err_reg  <= 1'b0;
    end else begin
      addr_prev_reg <= s_addr;
      addr_err_reg  <= !s_oe_n && (s_addr != addr_prev_reg);
    end
  end

  assign addr_err_out = addr_err_reg;
`else
  logic unused_oe_n;
  assign unused_oe_n  = s_oe_n;
  assign addr_err_out = 1'b0;
`endif

  assign pix_valid_out  = pix_valid_reg;
  assign pix_x_out      = pix_x_reg;
  assign pix_y_out      = pix_y_reg;
  assign pix_rgb_out    = pix_rgb_reg;
  assign row_done_out   = row_done_reg;
  assign frame_done_out = frame_done_reg;
  assign len_err_out    = len_err_reg;
  assign overrun_out    = overrun_reg;
  assign busy_out       = (state_reg == STREAM);

endmodule
